// File: rtl/sdram_arb.sv
// Two-client arbiter onto the SDRAM toggle req/ack port, round-robin by default.
// Define SDRAM_ARB_FIXED_PRIO_EN to give client 0 fixed priority on a tie.
module sdram_arb #(
  parameter int AW = 25,
  parameter int DW = 32
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [AW-1:0]     c0_addr,
  input  logic [DW-1:0]     c0_din,
  input  logic [DW/8-1:0]   c0_be,
  output logic              c0_ack,
  output logic [DW-1:0]     c0_dout,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [AW-1:0]     c1_addr,
  input  logic [DW-1:0]     c1_din,
  input  logic [DW/8-1:0]   c1_be,
  output logic              c1_ack,
  output logic [DW-1:0]     c1_dout,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic              sd_we,
  output logic [AW-1:0]     sd_addr,
  output logic [DW-1:0]     sd_din,
  output logic [DW/8-1:0]   sd_be,
  input  logic [DW-1:0]     sd_dout,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        state_dbg
);

  localparam int BW = DW / 8;

  // Handshake: a client holds cN_req (with stable command fields) until
  // cN_ack pulses for one cycle; the SDRAM side is done when sd_ack == sd_req.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sd_req_q, sd_req_d;
  logic            sd_we_q, sd_we_d;
  logic [AW-1:0]   sd_addr_q, sd_addr_d;
  logic [DW-1:0]   sd_din_q, sd_din_d;
  logic [BW-1:0]   sd_be_q, sd_be_d;
  logic            owner_q, owner_d;
  logic [DW-1:0]   c0_dout_q, c0_dout_d;
  logic [DW-1:0]   c1_dout_q, c1_dout_d;

  logic            any_req;
  logic            win;
  logic            issue;
  logic            complete;

  always_comb begin
    any_req = c0_req | c1_req;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    win = ~c0_req;
`else
    // On a tie the client that was not granted last goes next.
    win = (c0_req & c1_req) ? ~owner_q : c1_req;
`endif
    issue    = (state_q == ST_IDLE) && any_req;
    complete = (state_q == ST_WAIT) && (sd_ack == sd_req_q);
  end

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)  state_d = ST_WAIT;
      ST_WAIT: if (complete) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_req_d  = sd_req_q;
    sd_we_d   = sd_we_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_be_d   = sd_be_q;
    owner_d   = owner_q;
    c0_dout_d = c0_dout_q;
    c1_dout_d = c1_dout_q;
    if (issue) begin
      sd_req_d  = ~sd_req_q;
      owner_d   = win;
      sd_we_d   = win ? c1_we   : c0_we;
      sd_addr_d = win ? c1_addr : c0_addr;
      sd_din_d  = win ? c1_din  : c0_din;
      sd_be_d   = win ? c1_be   : c0_be;
    end
    if (complete) begin
      if (owner_q) c1_dout_d = sd_dout;
      else         c0_dout_d = sd_dout;
    end
  end

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      sd_req_q  <= 1'b0;
      sd_we_q   <= 1'b0;
      sd_addr_q <= '0;
      sd_din_q  <= '0;
      sd_be_q   <= '0;
      owner_q   <= 1'b1;
      c0_dout_q <= '0;
      c1_dout_q <= '0;
    end else begin
      sd_req_q  <= sd_req_d;
      sd_we_q   <= sd_we_d;
      sd_addr_q <= sd_addr_d;
      sd_din_q  <= sd_din_d;
      sd_be_q   <= sd_be_d;
      owner_q   <= owner_d;
      c0_dout_q <= c0_dout_d;
      c1_dout_q <= c1_dout_d;
    end
  end

  // Ack is the DONE state itself, so it lasts exactly one cycle.
  always_comb begin
    busy      = (state_q == ST_WAIT);
    c0_ack    = (state_q == ST_DONE) && !owner_q;
    c1_ack    = (state_q == ST_DONE) &&  owner_q;
    c0_dout   = c0_dout_q;
    c1_dout   = c1_dout_q;
    sd_req    = sd_req_q;
    sd_we     = sd_we_q;
    sd_addr   = sd_addr_q;
    sd_din    = sd_din_q;
    sd_be     = sd_be_q;
    owner     = owner_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: vector table plus reset, early-drop and contention sequences.
module tb_sdram_arb;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    logic          r0, r1, we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, rdata;
    logic [BW-1:0] b0, b1;
    int            lat;
    logic          win;
  } vec_t;

  logic clk_ram = 1'b0;
  logic reset   = 1'b1;
  logic c0_req = 1'b0, c0_we = 1'b0;
  logic [AW-1:0] c0_addr = '0;
  logic [DW-1:0] c0_din = '0;
  logic [BW-1:0] c0_be = '0;
  logic c1_req = 1'b0, c1_we = 1'b0;
  logic [AW-1:0] c1_addr = '0;
  logic [DW-1:0] c1_din = '0;
  logic [BW-1:0] c1_be = '0;
  logic c0_ack, c1_ack;
  logic [DW-1:0] c0_dout, c1_dout;
  logic sd_req, sd_we, busy, owner;
  logic sd_ack = 1'b0;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_din;
  logic [DW-1:0] sd_dout = '0;
  logic [BW-1:0] sd_be;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_sd_req = 1'b0;
  logic [DW-1:0] exp_dout [2];
  logic [DW-1:0] exp_q [$];
  vec_t vecs [6];

  int m_lat = 0;
  int m_cnt = 0;
  logic [DW-1:0] m_rdata = '0;

  sdram_arb #(.AW(AW), .DW(DW)) dut (
    .clk_ram(clk_ram), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_din(c0_din), .c0_be(c0_be),
    .c0_ack(c0_ack), .c0_dout(c0_dout),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_din(c1_din), .c1_be(c1_be),
    .c1_ack(c1_ack), .c1_dout(c1_dout),
    .sd_req(sd_req), .sd_ack(sd_ack), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_be(sd_be), .sd_dout(sd_dout),
    .busy(busy), .owner(owner), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk_ram = ~clk_ram;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SDRAM controller model: answers a toggle after m_lat extra negedges, shares reset.
  always @(negedge clk_ram or posedge reset) begin
    if (reset) begin
      sd_ack = 1'b0;
      m_cnt  = 0;
    end else if (sd_req !== sd_ack) begin
      if (m_cnt >= m_lat) begin
        sd_dout = m_rdata;
        sd_ack  = sd_req;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int who);
    bit seen;
    who  = -1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (c0_ack || c1_ack) begin
        who  = c1_ack ? 1 : 0;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic we0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic [BW-1:0] b0,
                              input logic r1, input logic we1, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d1, input logic [BW-1:0] b1,
                              input int lat, input logic [DW-1:0] rdata, input logic win);
    vec_t v;
    v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
    v.lat = lat; v.rdata = rdata; v.win = win;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_sd_req"},  sd_req,  0);
    chk({tag, "_sd_we"},   sd_we,   0);
    chk({tag, "_sd_addr"}, sd_addr, 0);
    chk({tag, "_sd_din"},  sd_din,  0);
    chk({tag, "_sd_be"},   sd_be,   0);
    chk({tag, "_c0_ack"},  c0_ack,  0);
    chk({tag, "_c1_ack"},  c1_ack,  0);
    chk({tag, "_c0_dout"}, c0_dout, 0);
    chk({tag, "_c1_dout"}, c1_dout, 0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_owner"},   owner,   1);
    chk({tag, "_state"},   state_dbg, 0);
  endtask

  // Driver: apply one table record, check issue, completion and the idle gap.
  task automatic apply_vec(input int idx, input vec_t v);
    int who;
    string p;
    p = $sformatf("v%0d", idx);
    c0_req = v.r0; c0_we = v.we0; c0_addr = v.a0; c0_din = v.d0; c0_be = v.b0;
    c1_req = v.r1; c1_we = v.we1; c1_addr = v.a1; c1_din = v.d1; c1_be = v.b1;
    m_lat = v.lat; m_rdata = v.rdata;
    tick();
    exp_sd_req = ~exp_sd_req;
    chk({p, "_sd_req"}, sd_req, exp_sd_req);
    chk({p, "_busy_issue"}, busy, 1);
    chk({p, "_owner"}, owner, v.win);
    chk({p, "_sd_we"},   sd_we,   v.win ? v.we1 : v.we0);
    chk({p, "_sd_addr"}, sd_addr, v.win ? v.a1  : v.a0);
    chk({p, "_sd_din"},  sd_din,  v.win ? v.d1  : v.d0);
    chk({p, "_sd_be"},   sd_be,   v.win ? v.b1  : v.b0);
    wait_ack(who);
    chk({p, "_grant"}, who, v.win);
    chk({p, "_c0_ack"}, c0_ack, !v.win);
    chk({p, "_c1_ack"}, c1_ack, v.win);
    chk({p, "_busy_done"}, busy, 0);
    exp_dout[v.win] = v.rdata;
    chk({p, "_c0_dout"}, c0_dout, exp_dout[0]);
    chk({p, "_c1_dout"}, c1_dout, exp_dout[1]);
    c0_req = 1'b0;
    c1_req = 1'b0;
    tick();
    chk({p, "_c0_ack_off"}, c0_ack, 0);
    chk({p, "_c1_ack_off"}, c1_ack, 0);
    tick();
    chk({p, "_busy_idle"}, busy, 0);
    chk({p, "_sd_req_idle"}, sd_req, exp_sd_req);
  endtask

  initial begin
    int who;
    int n0, n1;
    logic [DW-1:0] exp_g;
    logic v3_win;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    v3_win = 1'b0;
`else
    v3_win = 1'b1;
`endif
    vecs[0] = mk(1, 1, 25'h000100, 32'hDEADBEEF, 4'hF, 0, 0, 25'h0, 32'h0, 4'h0, 5, 32'hA5A5A5A5, 0);
    vecs[1] = mk(0, 0, 25'h0, 32'h0, 4'h0, 1, 0, 25'h040000, 32'h0, 4'hF, 3, 32'h12345678, 1);
    vecs[2] = mk(1, 0, 25'h1FFFFFF, 32'h0, 4'h0, 1, 1, 25'h000002, 32'h0BADF00D, 4'h3, 0, 32'hFFFFFFFF, 0);
    vecs[3] = mk(1, 1, 25'h0000AA, 32'h11112222, 4'h1, 1, 0, 25'h0000BB, 32'h33334444, 4'hC, 2, 32'h5A5A0000, v3_win);
    vecs[4] = mk(0, 0, 25'h0, 32'h0, 4'h0, 1, 0, 25'h123456, 32'h0, 4'h8, 1, 32'h00000001, 1);
    vecs[5] = mk(1, 1, 25'h0ABCDE, 32'h76543210, 4'h6, 0, 0, 25'h0, 32'h0, 4'h0, 2, 32'h80000000, 0);

    // Power-on reset
    tick();
    tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();
    chk("por_idle_busy", busy, 0);

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Early drop: request removed during WAIT still completes with one ack.
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 25'h000055; c0_be = 4'hF;
    m_lat = 4; m_rdata = 32'h0F0F0F0F;
    tick();
    exp_sd_req = ~exp_sd_req;
    chk("drop_sd_req", sd_req, exp_sd_req);
    chk("drop_busy", busy, 1);
    c0_req = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (c0_ack) n0++;
      if (c1_ack) n1++;
    end
    exp_dout[0] = 32'h0F0F0F0F;
    chk("drop_c0_ack_count", n0, 1);
    chk("drop_c1_ack_count", n1, 0);
    chk("drop_c0_dout", c0_dout, exp_dout[0]);
    chk("drop_c1_dout", c1_dout, exp_dout[1]);

    // Reset while in WAIT, asserted between clock edges.
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 25'h000003; c0_be = 4'hF;
    m_lat = 30; m_rdata = 32'h99999999;
    tick();
    exp_sd_req = ~exp_sd_req;
    chk("rstw_sd_req", sd_req, exp_sd_req);
    tick();
    tick();
    chk("rstw_in_wait", state_dbg, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("rstw");
    c0_req = 1'b0;
    tick();
    reset = 1'b0;
    exp_sd_req = 1'b0;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c0_ack) n0++;
      if (c1_ack) n1++;
    end
    chk("rstw_no_c0_ack", n0, 0);
    chk("rstw_no_c1_ack", n1, 0);
    apply_vec(6, mk(0, 0, 25'h0, 32'h0, 4'h0, 1, 0, 25'h040000, 32'h0, 4'hF, 1, 32'hCAFEF00D, 1));

    // Continuous contention for four completions.
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
`endif
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 25'h000010; c0_be = 4'hF;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 25'h000020; c1_din = 32'h13572468; c1_be = 4'hF;
    m_lat = 2; m_rdata = 32'h24682468;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
      exp_g = exp_q.pop_front();
      chk($sformatf("cont_grant%0d", i), who, exp_g);
      chk($sformatf("cont_busy%0d", i), busy, 0);
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    tick();
    tick();
    chk("cont_idle_busy", busy, 0);
    chk("cont_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
